// File: rtl/memory_data_unit.sv
// Memory address/data register pair with a handshaked read/write sequencer.
// Single outstanding access, MemAck handshake, bounded wait with sticky timeout flag.
module memory_data_unit #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       MemDataIn,
  input  logic              MemAck,
  output logic [31:0]       BusMuxInMDR,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemDataOut,
  output logic              MemReq,
  output logic              MemWE,
  output logic              Busy,
  output logic              Done,
  output logic              MemErr
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [31:0]       mdr;
  logic [CW-1:0]     cnt;
  logic              err;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      mar   <= '0;
      mdr   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MARin)
            mar <= BusMuxOut[ADDR_W-1:0];
          if (MDRin && !Read)
            mdr <= BusMuxOut;
          // A read start wins over a simultaneous write; the write is dropped.
          if (MDRin && Read) begin
            state <= RD_WAIT;
            cnt   <= '0;
            err   <= 1'b0;
          end else if (Write) begin
            state <= WR_WAIT;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (MemAck) begin
            if (state == RD_WAIT)
              mdr <= MemDataIn;
            state <= DONE;
          end else if (cnt == CW'(TIMEOUT)) begin
            err   <= 1'b1;
            state <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign BusMuxInMDR = mdr;
  assign MemDataOut  = mdr;
  assign MemAddr     = mar;
  assign MemReq      = (state == RD_WAIT) || (state == WR_WAIT);
  assign MemWE       = (state == WR_WAIT);
  assign Busy        = (state != IDLE);
  assign Done        = (state == DONE);
  assign MemErr      = err;

endmodule

// File: tb/tb_memory_data_unit.sv
// Directed bench for memory_data_unit; completions are scored against a queue
// of expected MDR/MemErr values pushed when each request is issued.
module tb_memory_data_unit;

  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              clear;
  logic [31:0]       BusMuxOut;
  logic              MARin, MDRin, Read, Write;
  logic [31:0]       MemDataIn;
  logic              MemAck;
  logic [31:0]       BusMuxInMDR;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemDataOut;
  logic              MemReq, MemWE, Busy, Done, MemErr;

  memory_data_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .clear       (clear),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .Read        (Read),
    .Write       (Write),
    .MemDataIn   (MemDataIn),
    .MemAck      (MemAck),
    .BusMuxInMDR (BusMuxInMDR),
    .MemAddr     (MemAddr),
    .MemDataOut  (MemDataOut),
    .MemReq      (MemReq),
    .MemWE       (MemWE),
    .Busy        (Busy),
    .Done        (Done),
    .MemErr      (MemErr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] mdr;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Completion monitor: every Done pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (Done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", {31'b0, Done}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.tag, "_mdr"}, BusMuxInMDR, e.mdr);
        check({e.tag, "_err"}, {31'b0, MemErr}, {31'b0, e.err});
      end
    end
  end

  task automatic run_txn(input string tag, input bit rd, input bit wr, input bit ld,
                         input int ack_at, input logic [31:0] rdata, input bit poke,
                         input logic [31:0] exp_mdr, input bit exp_err,
                         output int req_n, output int we_n,
                         output logic [ADDR_W-1:0] addr1, output logic [31:0] dout1);
    exp_t e;
    int   cyc;
    e.mdr = exp_mdr;
    e.err = exp_err;
    e.tag = tag;
    sbq.push_back(e);
    MDRin = rd | ld; Read = rd; Write = wr; MemDataIn = rdata;
    tick();
    MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
    check({tag, "_busy"}, {31'b0, Busy}, 32'd1);
    check({tag, "_errclr"}, {31'b0, MemErr}, 32'd0);
    req_n = 0; we_n = 0; cyc = 0;
    addr1 = MemAddr; dout1 = MemDataOut;
    while (MemReq === 1'b1 && cyc < 40) begin
      cyc++;
      req_n++;
      if (MemWE === 1'b1) we_n++;
      if (poke && cyc == 1) begin
        MARin = 1'b1; MDRin = 1'b1; Write = 1'b1; BusMuxOut = 32'h0000_00AB;
      end
      MemAck = (cyc == ack_at);
      tick();
      MemAck = 1'b0; MARin = 1'b0; MDRin = 1'b0; Write = 1'b0;
    end
    check({tag, "_done"}, {31'b0, Done}, 32'd1);
    tick();
    check({tag, "_idle"}, {31'b0, Busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_n, we_n;
    logic [ADDR_W-1:0] a1;
    logic [31:0] d1;

    clear = 1'b1; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    MemDataIn = '0; MemAck = 0;
    tick(); tick();
    clear = 1'b0;
    check("rst_memreq", {31'b0, MemReq}, 32'd0);
    check("rst_memwe",  {31'b0, MemWE},  32'd0);
    check("rst_busy",   {31'b0, Busy},   32'd0);
    check("rst_done",   {31'b0, Done},   32'd0);
    check("rst_memerr", {31'b0, MemErr}, 32'd0);
    check("rst_mdr",    BusMuxInMDR,     32'd0);
    check("rst_mar",    {23'b0, MemAddr}, 32'd0);

    // Ack while idle must not start anything.
    MemAck = 1'b1; tick(); MemAck = 1'b0;
    check("idle_ack_busy", {31'b0, Busy}, 32'd0);
    check("idle_ack_done", {31'b0, Done}, 32'd0);

    // Bus loads.
    BusMuxOut = 32'h0000_0042; MARin = 1'b1; tick(); MARin = 1'b0;
    check("busload_busy1", {31'b0, Busy}, 32'd0);
    BusMuxOut = 32'hDEAD_BEEF; MDRin = 1'b1; tick(); MDRin = 1'b0;
    check("busload_mar",   {23'b0, MemAddr}, 32'h042);
    check("busload_mdr",   BusMuxInMDR, 32'hDEAD_BEEF);
    check("busload_busy2", {31'b0, Busy}, 32'd0);

    // Read, ack on 3rd wait cycle.
    BusMuxOut = 32'h0000_0010; MARin = 1'b1; tick(); MARin = 1'b0;
    run_txn("read", 1, 0, 0, 3, 32'h1234_5678, 0, 32'h1234_5678, 0, req_n, we_n, a1, d1);
    check("read_req_cycles", req_n, 32'd3);
    check("read_we_cycles",  we_n,  32'd0);
    check("read_addr",       {23'b0, a1}, 32'h010);

    // Write, immediate ack.
    BusMuxOut = 32'hA5A5_A5A5; MDRin = 1'b1; tick(); MDRin = 1'b0;
    BusMuxOut = 32'h0000_01FF; MARin = 1'b1; tick(); MARin = 1'b0;
    run_txn("write", 0, 1, 0, 1, 32'hFFFF_0000, 0, 32'hA5A5_A5A5, 0, req_n, we_n, a1, d1);
    check("write_req_cycles", req_n, 32'd1);
    check("write_we_cycles",  we_n,  32'd1);
    check("write_addr",       {23'b0, a1}, 32'h1FF);
    check("write_dout",       d1, 32'hA5A5_A5A5);
    check("write_dout_after", MemDataOut, 32'hA5A5_A5A5);

    // Write launched in the same cycle as an MDR bus load uses the new value.
    BusMuxOut = 32'h600D_F00D;
    run_txn("ldwrite", 0, 1, 1, 2, 32'h0, 0, 32'h600D_F00D, 0, req_n, we_n, a1, d1);
    check("ldwrite_dout",     d1, 32'h600D_F00D);
    check("ldwrite_we_cycles", we_n, 32'd2);

    // Timeout: counter runs 0..TIMEOUT, aborting on the edge it sits at TIMEOUT.
    run_txn("timeout", 1, 0, 0, 0, 32'hBAD0_BAD0, 0, 32'h600D_F00D, 1, req_n, we_n, a1, d1);
    check("timeout_req_cycles", req_n, TIMEOUT + 1);
    check("timeout_sticky",     {31'b0, MemErr}, 32'd1);
    tick();
    check("timeout_sticky2",    {31'b0, MemErr}, 32'd1);
    run_txn("clrwrite", 0, 1, 0, 1, 32'h0, 0, 32'h600D_F00D, 0, req_n, we_n, a1, d1);

    // Ack on the abort edge wins.
    run_txn("ack_limit", 1, 0, 0, TIMEOUT + 1, 32'h1357_2468, 0, 32'h1357_2468, 0,
            req_n, we_n, a1, d1);
    check("ack_limit_req_cycles", req_n, TIMEOUT + 1);

    // Collision: read wins, write dropped; bus controls ignored while busy.
    run_txn("collide", 1, 1, 0, 2, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0, req_n, we_n, a1, d1);
    check("collide_we_cycles", we_n, 32'd0);
    check("collide_mar",       {23'b0, MemAddr}, 32'h1FF);
    tick();
    check("collide_no_write",  {31'b0, Busy}, 32'd0);

    // Reset during the 2nd WR_WAIT cycle.
    Write = 1'b1; tick(); Write = 1'b0;
    check("rstmid_we1", {31'b0, MemWE}, 32'd1);
    tick();
    check("rstmid_we2", {31'b0, MemWE}, 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("rstmid_memreq", {31'b0, MemReq}, 32'd0);
    check("rstmid_busy",   {31'b0, Busy},   32'd0);
    check("rstmid_done",   {31'b0, Done},   32'd0);
    check("rstmid_memerr", {31'b0, MemErr}, 32'd0);
    check("rstmid_mdr",    BusMuxInMDR,     32'd0);
    tick();
    check("rstmid_done2",  {31'b0, Done},   32'd0);

    check("pending_done", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_data_unit.md
MEMORY_DATA_UNIT -- requirements
Module: memory_data_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, which sets the MAR and memory address width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, which sets the maximum number of wait cycles for MemAck before abort.
REQ-003 The block SHALL have one clock, clock, and a synchronous, active-high reset, clear.
REQ-004 The block SHALL have the following ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous active-high reset
- BusMuxOut  in  32  shared bus value
- MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0]
- MDRin  in  1  load MDR from the bus (Read=0) or start a memory read (Read=1)
- Read  in  1  memory read request qualifier
- Write  in  1  memory write request (stores MDR to mem[MAR])
- MemDataIn  in  32  read data from memory
- MemAck  in  1  memory completion strobe
- BusMuxInMDR  out  32  MDR contents, feeding the bus mux MDR input
- MemAddr  out  ADDR_W  current MAR
- MemDataOut  out  32  current MDR
- MemReq  out  1  memory request active
- MemWE  out  1  write enable, valid while MemReq=1
- Busy  out  1  transaction in progress
- Done  out  1  one-cycle completion pulse
- MemErr  out  1  sticky timeout flag

Function
REQ-005 The FSM SHALL have four states: IDLE, RD_WAIT, WR_WAIT and DONE.
REQ-006 In IDLE, MARin=1 SHALL load MAR <= BusMuxOut[ADDR_W-1:0] at the clock edge.
REQ-007 In IDLE, MDRin=1 with Read=0 SHALL load MDR <= BusMuxOut; Write is still evaluated that cycle.
REQ-008 In IDLE, Read=1 with MDRin=1 SHALL enter RD_WAIT, clear the wait counter and clear MemErr.
REQ-009 In IDLE, Write=1 with no read start SHALL enter WR_WAIT, clear the wait counter and clear MemErr.
REQ-010 When a read start and Write are both asserted in IDLE, the read SHALL win and the write SHALL be dropped, not queued.
REQ-011 When a write starts in the same cycle as an MDR bus load, the write SHALL store the newly loaded MDR value.
REQ-012 The outputs SHALL be driven as follows:
- MemReq=1 in RD_WAIT and WR_WAIT.
- MemWE=1 only in WR_WAIT.
- Busy=1 whenever state != IDLE.
- Done=1 only in DONE.
- All of these are decoded from registered state.
REQ-013 MemAddr SHALL equal MAR and MemDataOut SHALL equal MDR at all times; both are held constant while Busy=1.
REQ-014 In RD_WAIT with MemAck=1 sampled at the edge, the block SHALL set MDR <= MemDataIn and go to DONE.
REQ-015 In WR_WAIT with MemAck=1, the block SHALL go to DONE and leave MDR unchanged.
REQ-016 In RD_WAIT or WR_WAIT with MemAck=0, the wait counter SHALL increment by 1 each cycle.
REQ-017 When the counter equals TIMEOUT with MemAck=0, the block SHALL set MemErr=1 and go to DONE, leaving MDR unchanged; an ack arriving on that same edge SHALL take priority over the abort.
REQ-018 DONE SHALL always return to IDLE after exactly one cycle.
REQ-019 Latency: with a request accepted at edge N and MemAck first high at edge N+k (k>=1), Done SHALL be high during cycle N+k to N+k+1, and a new request SHALL be accepted no earlier than edge N+k+2.
REQ-020 MARin, MDRin, Read and Write asserted while Busy=1 SHALL be ignored entirely.
REQ-021 MemAck sampled in IDLE or DONE SHALL be ignored.
REQ-022 The wait counter SHALL saturate and never wrap; its width SHALL be ceil(log2(TIMEOUT+1)).
REQ-023 MemErr SHALL remain set until clear or the next accepted request.

Reset
REQ-024 When clear=1 at a rising edge, the block SHALL set state=IDLE, MAR=0, MDR=0, wait counter=0 and MemErr=0, which makes every output 0 the following cycle.
REQ-025 clear SHALL override all other inputs, including mid-transaction; an aborted transaction SHALL produce no Done pulse and SHALL leave the reset values in MDR.

Verification
REQ-026 Bus load test: BusMuxOut=0x0000_0042 with MARin=1, then BusMuxOut=0xDEAD_BEEF with MDRin=1 -> MemAddr=0x042 and BusMuxInMDR=0xDEADBEEF, with Busy=0 throughout.
REQ-027 Read test: MAR=0x10, Read=MDRin=1, MemAck high on the 3rd wait cycle with MemDataIn=0x1234_5678 -> MemReq=1 with MemWE=0 for 3 cycles, then MDR=0x12345678, one Done pulse, MemErr=0.
REQ-028 Write test: MDR=0xA5A5_A5A5, MAR=0x1FF, Write=1, immediate ack -> MemWE=1 for 1 cycle, MemDataOut=0xA5A5A5A5, MemAddr=0x1FF, Done pulse, MDR unchanged.
REQ-029 Timeout test: a read with MemAck held at 0 -> MemErr=1 after TIMEOUT=15 wait cycles, MDR unchanged, Done pulse; the next accepted write clears MemErr.
REQ-030 Collision test: Read=MDRin=Write=1 in IDLE -> read only, MemWE never asserted; a MARin pulse while Busy -> MemAddr unchanged.
REQ-031 Reset test: clear=1 in the 2nd cycle of WR_WAIT -> the next cycle shows MemReq=0, Busy=0, Done=0, MemErr=0 and BusMuxInMDR=0.
